// File: rtl/ll_window_accum_if.sv
// ll_window_accum_if: sample stream in, line-length feature and status out
interface ll_window_accum_if #(
    parameter int data_width = 32,
    parameter int WIN        = 16
);
    localparam int acc_width = data_width + $clog2(WIN);
    logic [data_width-1:0] din;
    logic                  din_valid;
    logic                  clear;
    logic [acc_width-1:0]  threshold;
    logic [acc_width-1:0]  ll_sum;
    logic                  sum_valid;
    logic                  window_full;
    logic                  detect;
    logic                  sat_flag;
    modport master (
        output din, din_valid, clear, threshold,
        input  ll_sum, sum_valid, window_full, detect, sat_flag
    );
    modport slave (
        input  din, din_valid, clear, threshold,
        output ll_sum, sum_valid, window_full, detect, sat_flag
    );
endinterface

// File: rtl/ll_window_accum.sv
// ll_window_accum: sliding-window line-length sum over WIN samples, emitted every STRIDE samples
module ll_window_accum #(
    parameter int data_width = 32,
    parameter int WIN        = 16,
    parameter int STRIDE     = 1
) (
    input  logic clk,
    input  logic rst_n,
    ll_window_accum_if.slave bus
);
    localparam int AW = data_width + $clog2(WIN);
    localparam int PW = $clog2(WIN);
    localparam int SW = $clog2(STRIDE + 1);
    localparam logic [PW-1:0] PLAST = PW'(WIN - 1);
    localparam logic [SW-1:0] SLAST = SW'(STRIDE - 1);
    localparam logic [data_width-1:0] DMAX = {1'b0, {(data_width-1){1'b1}}};

    typedef enum logic {FILL, RUN} state_t;
    state_t state, state_n;

    logic [data_width-1:0] mem [WIN];
    logic [data_width-1:0] d, old;
    logic [PW-1:0]         wr_ptr;
    logic [SW-1:0]         scnt;
    logic [AW-1:0]         ll_sum, sum_next;
    logic                  acc, neg, fire, sum_valid, window_full, detect, sat_flag;

    assign acc      = bus.din_valid && !bus.clear;
    assign neg      = bus.din[data_width-1];
    assign d        = neg ? DMAX : bus.din;
    // During FILL the slot at wr_ptr holds stale data, so nothing is removed
    assign old      = mem[wr_ptr];
    assign sum_next = ll_sum + AW'(d) - (state == RUN ? AW'(old) : '0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FILL;
        else state <= state_n;

    always_comb begin
        state_n = state;
        fire    = 1'b0;
        if (bus.clear) state_n = FILL;
        else if (acc) begin
            fire    = (state == FILL) ? (wr_ptr == PLAST) : (scnt == SLAST);
            state_n = fire ? RUN : state;
        end
    end

    always_ff @(posedge clk)
        if (acc) mem[wr_ptr] <= d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ll_sum      <= '0;
            wr_ptr      <= '0;
            scnt        <= '0;
            sum_valid   <= 1'b0;
            window_full <= 1'b0;
            detect      <= 1'b0;
            sat_flag    <= 1'b0;
        end else if (bus.clear) begin
            ll_sum      <= '0;
            wr_ptr      <= '0;
            scnt        <= '0;
            sum_valid   <= 1'b0;
            window_full <= 1'b0;
            detect      <= 1'b0;
        end else begin
            sum_valid <= fire;
            if (acc) begin
                ll_sum <= sum_next;
                wr_ptr <= wr_ptr + 1'b1;
                scnt   <= (fire || state == FILL) ? '0 : scnt + 1'b1;
                if (fire) window_full <= 1'b1;
                if (fire) detect <= sum_next > bus.threshold;
                if (neg) sat_flag <= 1'b1;
            end
        end
    end

    assign bus.ll_sum      = ll_sum;
    assign bus.sum_valid   = sum_valid;
    assign bus.window_full = window_full;
    assign bus.detect      = detect;
    assign bus.sat_flag    = sat_flag;
endmodule

// File: tb/tb_ll_window_accum.sv
// tb_ll_window_accum: table vectors plus random stream against a sample-history model, STRIDE 1 and 2
module tb_ll_window_accum;
    localparam int DW  = 32;
    localparam int WIN = 4;
    localparam int AW  = DW + $clog2(WIN);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ll_window_accum_if #(.data_width(DW), .WIN(WIN)) b1 ();
    ll_window_accum_if #(.data_width(DW), .WIN(WIN)) b2 ();

    ll_window_accum #(.data_width(DW), .WIN(WIN), .STRIDE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    ll_window_accum #(.data_width(DW), .WIN(WIN), .STRIDE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    logic [DW-1:0] hist[$];
    int   n = 0;
    logic msv[2];
    logic mdet[2];
    logic msat = 1'b0;
    int   str[2] = '{1, 2};

    typedef struct {
        logic          v;
        logic          c;
        logic [DW-1:0] d;
        logic [AW-1:0] s1;
        logic          sv1;
        logic [AW-1:0] s2;
        logic          sv2;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    endtask

    function automatic logic [AW-1:0] msum();
        logic [AW-1:0] s = '0;
        foreach (hist[i]) s += AW'(hist[i]);
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        n = 0;
        msat = 1'b0;
        for (int k = 0; k < 2; k++) begin msv[k] = 1'b0; mdet[k] = 1'b0; end
    endtask

    task automatic model(input logic v, input logic c, input logic [DW-1:0] d, input logic [AW-1:0] t);
        if (c) begin
            hist.delete();
            n = 0;
            for (int k = 0; k < 2; k++) begin msv[k] = 1'b0; mdet[k] = 1'b0; end
        end else if (v) begin
            if (d[DW-1]) msat = 1'b1;
            hist.push_back(d[DW-1] ? 32'h7FFF_FFFF : d);
            if (hist.size() > WIN) void'(hist.pop_front());
            n++;
            for (int k = 0; k < 2; k++) begin
                msv[k] = (n >= WIN) && ((n - WIN) % str[k] == 0);
                if (msv[k]) mdet[k] = msum() > t;
            end
        end else begin
            msv[0] = 1'b0;
            msv[1] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("ll_sum_s1", 64'(b1.ll_sum), 64'(msum()));
        check("sum_valid_s1", 64'(b1.sum_valid), 64'(msv[0]));
        check("window_full_s1", 64'(b1.window_full), 64'(n >= WIN));
        check("detect_s1", 64'(b1.detect), 64'(mdet[0]));
        check("sat_flag_s1", 64'(b1.sat_flag), 64'(msat));
        check("ll_sum_s2", 64'(b2.ll_sum), 64'(msum()));
        check("sum_valid_s2", 64'(b2.sum_valid), 64'(msv[1]));
        check("window_full_s2", 64'(b2.window_full), 64'(n >= WIN));
        check("detect_s2", 64'(b2.detect), 64'(mdet[1]));
        check("sat_flag_s2", 64'(b2.sat_flag), 64'(msat));
    endtask

    task automatic drive(input logic v, input logic c, input logic [DW-1:0] d, input logic [AW-1:0] t);
        b1.din_valid = v; b1.clear = c; b1.din = d; b1.threshold = t;
        b2.din_valid = v; b2.clear = c; b2.din = d; b2.threshold = t;
    endtask

    task automatic step(input logic v, input logic c, input logic [DW-1:0] d, input logic [AW-1:0] t);
        drive(v, c, d, t);
        @(posedge clk);
        #1;
        model(v, c, d, t);
        compare_all();
    endtask

    task automatic rand_steps(input int cnt);
        logic [DW-1:0] d;
        for (int i = 0; i < cnt; i++) begin
            d = ($urandom_range(0, 15) == 0) ? {1'b1, 31'($urandom)} : DW'($urandom_range(0, 1000));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, d, AW'($urandom_range(0, 4000)));
        end
    endtask

    initial begin
        tbl[0]  = '{1, 0, 1, 1, 0, 1, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 1, 0};
        tbl[2]  = '{1, 0, 2, 3, 0, 3, 0};
        tbl[3]  = '{0, 0, 0, 3, 0, 3, 0};
        tbl[4]  = '{1, 0, 3, 6, 0, 6, 0};
        tbl[5]  = '{1, 0, 4, 10, 1, 10, 1};
        tbl[6]  = '{0, 0, 0, 10, 0, 10, 0};
        tbl[7]  = '{1, 0, 5, 14, 1, 14, 0};
        tbl[8]  = '{1, 0, 6, 18, 1, 18, 1};
        tbl[9]  = '{1, 0, 7, 22, 1, 22, 0};
        tbl[10] = '{1, 0, 8, 26, 1, 26, 1};
        tbl[11] = '{1, 0, 9, 30, 1, 30, 0};
        tbl[12] = '{1, 1, 100, 0, 0, 0, 0};
        tbl[13] = '{1, 0, 1, 1, 0, 1, 0};
        tbl[14] = '{1, 0, 1, 2, 0, 2, 0};
        tbl[15] = '{1, 0, 1, 3, 0, 3, 0};
        tbl[16] = '{1, 0, 1, 4, 1, 4, 1};
        tbl[17] = '{1, 0, 32'h8000_0000, 34'h0_8000_0002, 1, 34'h0_8000_0002, 0};

        model_reset();
        drive(0, 0, 0, 20);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d, 20);
            check("tbl_sum_s1", 64'(b1.ll_sum), 64'(tbl[i].s1));
            check("tbl_sv_s1", 64'(b1.sum_valid), 64'(tbl[i].sv1));
            check("tbl_sum_s2", 64'(b2.ll_sum), 64'(tbl[i].s2));
            check("tbl_sv_s2", 64'(b2.sum_valid), 64'(tbl[i].sv2));
        end

        step(0, 1, 0, 20);
        check("sat_kept_after_clear", 64'(b1.sat_flag), 64'd1);
        check("clear_zero_sum", 64'(b1.ll_sum), 64'd0);

        rand_steps(400);

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        for (int i = 0; i < WIN - 1; i++) step(1, 0, DW'(i + 1), 0);
        check("no_early_valid", 64'(b1.sum_valid), 64'd0);
        step(1, 0, 4, 0);
        check("first_valid_after_reset", 64'(b1.sum_valid), 64'd1);

        rand_steps(300);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
